// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the MEM-stage load/store port. It accepts one
// word-aligned read or byte-masked write per req/ack handshake. After
// WAIT_CYCLES wait states it serves the access from an internal word array.
// Misaligned or out-of-range accesses are flagged with err_o and not performed.
//
// Parameters:
//   ADDR_WIDTH  : log2 of array depth in 32-bit words
//   WAIT_CYCLES : wait states between acceptance and ack (0..15)
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset (array contents kept)
//   req_i    in   1  request valid, held with its fields until ack_o seen
//   we_i     in   1  1 = write, 0 = read
//   addr_i   in  32  byte address
//   sel_i    in   4  byte-lane write enables
//   wdata_i  in  32  write data
//   rdata_o  out 32  read data, valid while ack_o = 1
//   ack_o    out  1  one-cycle completion pulse
//   err_o    out  1  access error, valid while ack_o = 1
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  // Effective request: the live inputs while idle, otherwise the latched copy.
  // With WAIT_CYCLES = 0 the access executes on the accepting edge itself.
  logic                  eff_we_s;
  logic [31:0]           eff_addr_s;
  logic [3:0]            eff_sel_s;
  logic [31:0]           eff_wdata_s;
  logic                  acc_err_s;
  logic [ADDR_WIDTH-1:0] idx_s;
  logic                  commit_s;
  logic                  wr_en_s;

  // Select the effective request fields and decode the access.
  always_comb begin
    if (state_q == IDLE) begin
      eff_we_s    = we_i;
      eff_addr_s  = addr_i;
      eff_sel_s   = sel_i;
      eff_wdata_s = wdata_i;
    end else begin
      eff_we_s    = we_q;
      eff_addr_s  = addr_q;
      eff_sel_s   = sel_q;
      eff_wdata_s = wdata_q;
    end
    // Any address bit above the array span or below word alignment is an error.
    acc_err_s = (eff_addr_s[1:0] != 2'b00) ||
                ((eff_addr_s >> (ADDR_WIDTH + 2)) != 32'h0);
    idx_s     = eff_addr_s[ADDR_WIDTH+1:2];
  end

  // Next-state, wait counter, request latch and response outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          sel_d   = sel_i;
          wdata_d = wdata_i;
          if (WAIT_CYCLES != 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Leave on the edge where the counter reaches 1.
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Outputs are loaded on the edge that enters RESP.
    commit_s = (state_d == RESP) && (state_q != RESP);
    if (commit_s) begin
      ack_d = 1'b1;
      err_d = acc_err_s;
      if (eff_we_s || acc_err_s) begin
        rdata_d = 32'h0;
      end else begin
        rdata_d = mem[idx_s];
      end
    end else begin
      ack_d = 1'b0;
      err_d = 1'b0;
    end

    wr_en_s = commit_s && eff_we_s && !acc_err_s;
  end

  // State, latched request and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      sel_q   <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Byte-masked array write; reset suppresses a commit and never clears data.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      for (int n = 0; n < 4; n++) begin
        if (eff_sel_s[n]) begin
          mem[idx_s][8*n +: 8] <= eff_wdata_s[8*n +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;

endmodule
